// File: rtl/layer_serializer.sv
// Purpose: collects per-neuron results (each on its own valid bit) and replays them as a serial word stream, neuron 0 first.
// Latency: word 0 appears two cycles after the cycle that completes a set; back-to-back sets stream with no gap.
// Backpressure: none; downstream must accept every cycle, and results arriving while a set is pending are dropped and flagged in overrun.
module layer_serializer #(
    parameter int neurons   = 10,
    parameter int dataWidth = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [neurons-1:0]            layer_out_valid,
    input  logic [neurons*dataWidth-1:0]  layer_out_data,
    output logic                          ser_out_valid,
    output logic [dataWidth-1:0]          ser_out_data,
    output logic                          ser_out_last,
    output logic                          busy,
    output logic                          overrun
);

    localparam int CW = (neurons > 1) ? $clog2(neurons) : 1;
    localparam logic [CW-1:0] LAST = CW'(neurons - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [neurons-1:0]     flag;
    logic [neurons-1:0]     merged;
    logic                   pending;
    logic                   complete;
    logic                   load;
    logic                   vld_nxt;
    logic                   last_nxt;
    logic [dataWidth-1:0]   dat_nxt;
    logic [dataWidth-1:0]   coll_data  [neurons];
    logic [dataWidth-1:0]   coll_merge [neurons];
    logic [dataWidth-1:0]   shift_buf  [neurons];

    // Collect view: this cycle's accepted words merged over the stored ones, and set completion.
    always_comb begin
        merged   = flag | layer_out_valid;
        complete = !pending && (&merged);
        for (int i = 0; i < neurons; i++) begin
            coll_merge[i] = (layer_out_valid[i] && !pending)
                          ? layer_out_data[i*dataWidth +: dataWidth]
                          : coll_data[i];
        end
    end

    // Collect and shift buffers carry no reset; their contents are qualified by flags/pending/state.
    always_ff @(posedge clk) begin
        for (int i = 0; i < neurons; i++) begin
            coll_data[i] <= coll_merge[i];
            if (load) begin
                shift_buf[i] <= coll_merge[i];
            end
        end
    end

    // Flags, pending handshake between collect and shift, and the sticky drop indicator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag    <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (pending) begin
                if (|layer_out_valid) begin
                    overrun <= 1'b1;
                end
            end else if (complete) begin
                flag <= '0;
            end else begin
                flag <= merged;
            end
            // A set completing on the last-word cycle is loaded straight away and never pends.
            if (load) begin
                pending <= 1'b0;
            end else if (complete) begin
                pending <= 1'b1;
            end
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            ser_out_valid <= 1'b0;
            ser_out_data  <= '0;
            ser_out_last  <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            ser_out_valid <= vld_nxt;
            ser_out_data  <= dat_nxt;
            ser_out_last  <= last_nxt;
        end
    end

    // Next state and next output word; cnt indexes the word currently on the output.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        vld_nxt   = 1'b0;
        dat_nxt   = '0;
        last_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    vld_nxt   = 1'b1;
                    dat_nxt   = coll_merge[0];
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    if (pending || complete) begin
                        load    = 1'b1;
                        cnt_nxt = '0;
                        vld_nxt = 1'b1;
                        dat_nxt = coll_merge[0];
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt  = cnt + CW'(1);
                    vld_nxt  = 1'b1;
                    dat_nxt  = shift_buf[cnt_nxt];
                    last_nxt = (cnt_nxt == LAST);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_layer_serializer.sv
module tb_layer_serializer;

    localparam int N = 10;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     lv;
    logic [N*W-1:0]   ld;
    logic             ser_out_valid;
    logic [W-1:0]     ser_out_data;
    logic             ser_out_last;
    logic             busy;
    logic             overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    layer_serializer #(.neurons(N), .dataWidth(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .layer_out_valid (lv),
        .layer_out_data  (ld),
        .ser_out_valid   (ser_out_valid),
        .ser_out_data    (ser_out_data),
        .ser_out_last    (ser_out_last),
        .busy            (busy),
        .overrun         (overrun)
    );

    task automatic idle_in();
        lv = '0;
        for (int i = 0; i < N; i++) ld[i*W +: W] = 16'hDEAD;
    endtask

    task automatic fill(input logic [W-1:0] base, input logic [N-1:0] vmask);
        lv = vmask;
        for (int i = 0; i < N; i++) ld[i*W +: W] = base + W'(i);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_in();
        #1;
        n_checks++;
        if (ser_out_valid !== 1'b0 || ser_out_data !== '0 || ser_out_last !== 1'b0 ||
            busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: valid=%b data=%h last=%b busy=%b overrun=%b, required all 0",
                     ser_out_valid, ser_out_data, ser_out_last, busy, overrun);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_set();
        logic [W-1:0] exp;
        fill(16'h0100, '1);
        @(negedge clk);
        idle_in();
        n_checks++;
        if (ser_out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_set early: valid=%b busy=%b, required 0 0", ser_out_valid, busy);
        end
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            exp = 16'h0100 + W'(k);
            n_checks++;
            if (ser_out_valid !== 1'b1 || ser_out_data !== exp ||
                ser_out_last !== (k == N-1) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL full_set word %0d: valid=%b data=%h last=%b busy=%b, required 1 %h %b 1",
                         k, ser_out_valid, ser_out_data, ser_out_last, busy, exp, k == N-1);
            end
        end
        @(negedge clk);
        n_checks++;
        if (ser_out_valid !== 1'b0 || busy !== 1'b0 || ser_out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL full_set end: valid=%b busy=%b last=%b, required 0 0 0",
                     ser_out_valid, busy, ser_out_last);
        end
    endtask

    task automatic test_one_per_cycle();
        logic [W-1:0] exp;
        for (int b = N-1; b >= 0; b--) begin
            idle_in();
            lv[b] = 1'b1;
            ld[b*W +: W] = 16'h0200 + W'(b);
            @(negedge clk);
            idle_in();
            n_checks++;
            if (ser_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL one_per_cycle early after bit %0d: valid=%b, required 0", b, ser_out_valid);
            end
        end
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            exp = 16'h0200 + W'(k);
            n_checks++;
            if (ser_out_valid !== 1'b1 || ser_out_data !== exp || ser_out_last !== (k == N-1)) begin
                n_fail++;
                $display("FAIL one_per_cycle word %0d: valid=%b data=%h last=%b, required 1 %h %b",
                         k, ser_out_valid, ser_out_data, ser_out_last, exp, k == N-1);
            end
        end
        @(negedge clk);
        n_checks++;
        if (ser_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL one_per_cycle end: valid=%b, required 0", ser_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp;
        fill(16'h0300, '1);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        for (int k = 0; k < 2*N; k++) begin
            exp = (k < N) ? 16'h0300 + W'(k) : 16'h0400 + W'(k - N);
            n_checks++;
            if (ser_out_valid !== 1'b1 || ser_out_data !== exp ||
                ser_out_last !== (k == N-1 || k == 2*N-1) || overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL back_to_back word %0d: valid=%b data=%h last=%b overrun=%b, required 1 %h %b 0",
                         k, ser_out_valid, ser_out_data, ser_out_last, overrun, exp,
                         (k == N-1 || k == 2*N-1));
            end
            if (k == 3) fill(16'h0400, '1);
            else        idle_in();
            @(negedge clk);
        end
        n_checks++;
        if (ser_out_valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back end: valid=%b overrun=%b, required 0 0", ser_out_valid, overrun);
        end
    endtask

    task automatic test_overrun();
        logic [W-1:0] exp;
        fill(16'h0500, '1);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        for (int k = 0; k < 2*N; k++) begin
            exp = (k < N) ? 16'h0500 + W'(k) : 16'h0600 + W'(k - N);
            n_checks++;
            if (ser_out_valid !== 1'b1 || ser_out_data !== exp ||
                ser_out_last !== (k == N-1 || k == 2*N-1) || overrun !== (k >= 6)) begin
                n_fail++;
                $display("FAIL overrun word %0d: valid=%b data=%h last=%b overrun=%b, required 1 %h %b %b",
                         k, ser_out_valid, ser_out_data, ser_out_last, overrun, exp,
                         (k == N-1 || k == 2*N-1), k >= 6);
            end
            if (k == 2)      fill(16'h0600, '1);
            else if (k == 5) fill(16'h0700, '1);
            else             idle_in();
            @(negedge clk);
        end
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (ser_out_valid !== 1'b0 || overrun !== 1'b1) begin
                n_fail++;
                $display("FAIL overrun tail %0d: valid=%b overrun=%b, required 0 1", j, ser_out_valid, overrun);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [W-1:0] exp;
        fill(16'h0800, '1);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            exp = 16'h0800 + W'(k);
            n_checks++;
            if (ser_out_valid !== 1'b1 || ser_out_data !== exp) begin
                n_fail++;
                $display("FAIL mid_reset pre word %0d: valid=%b data=%h, required 1 %h",
                         k, ser_out_valid, ser_out_data, exp);
            end
            if (k < 4) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ser_out_valid !== 1'b0 || ser_out_data !== '0 || ser_out_last !== 1'b0 ||
            busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset async: valid=%b data=%h last=%b busy=%b overrun=%b, required all 0",
                     ser_out_valid, ser_out_data, ser_out_last, busy, overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ser_out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset after release: valid=%b busy=%b, required 0 0", ser_out_valid, busy);
        end
        fill(16'h0900, '1);
        @(negedge clk);
        idle_in();
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            exp = 16'h0900 + W'(k);
            n_checks++;
            if (ser_out_valid !== 1'b1 || ser_out_data !== exp || ser_out_last !== (k == N-1)) begin
                n_fail++;
                $display("FAIL mid_reset restream word %0d: valid=%b data=%h last=%b, required 1 %h %b",
                         k, ser_out_valid, ser_out_data, ser_out_last, exp, k == N-1);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_overwrite();
        logic [W-1:0] exp;
        idle_in();
        lv[3] = 1'b1;
        ld[3*W +: W] = 16'hAAAA;
        @(negedge clk);
        idle_in();
        lv[3] = 1'b1;
        ld[3*W +: W] = 16'hBBBB;
        @(negedge clk);
        fill(16'h0A00, ~(N'(1) << 3));
        ld[3*W +: W] = 16'hDEAD;
        @(negedge clk);
        idle_in();
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            exp = (k == 3) ? 16'hBBBB : 16'h0A00 + W'(k);
            n_checks++;
            if (ser_out_valid !== 1'b1 || ser_out_data !== exp || ser_out_last !== (k == N-1)) begin
                n_fail++;
                $display("FAIL overwrite word %0d: valid=%b data=%h last=%b, required 1 %h %b",
                         k, ser_out_valid, ser_out_data, ser_out_last, exp, k == N-1);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_set();
        test_one_per_cycle();
        test_back_to_back();
        test_overrun();
        test_reset_mid_stream();
        test_overwrite();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
